// File: rtl/odd_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : odd_parity_serial_tx
// Brief    : Serial transmitter that sends one word per frame: start bit (0),
//            DATA_W data bits LSB first, odd-parity bit, stop bit (1).
//            Each bit is held for CLKS_PER_BIT clocks; the line idles high.
// Revision : 1.0 - initial release
// ============================================================================
module odd_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              p,
    output logic              busy
);

    // Bit-period counter is 8 bits wide to cover the full 1..255 range.
    localparam int                 c_IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]         c_CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_shreg;
    logic               r_tx;
    logic               r_p;

    logic               w_accept;
    logic               w_bit_end;
    logic [DATA_W-1:0]  w_shift_next;

    // Reset gates in_ready so an acceptance can never win over reset.
    assign in_ready     = (r_state == c_IDLE) && !rst;
    assign busy         = (r_state != c_IDLE);
    assign tx           = r_tx;
    assign p            = r_p;
    assign w_accept     = in_valid && in_ready;
    assign w_bit_end    = (r_cnt == c_CNT_LAST);
    assign w_shift_next = r_shreg >> 1;

    // Frame sequencer: tx is registered alongside each state change so the
    // new bit appears on the first cycle of its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
            r_p     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_accept) begin
                        r_state <= c_START;
                        r_shreg <= in_data;
                        r_p     <= ~^in_data;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_state <= c_DATA;
                        r_cnt   <= 8'd0;
                        r_tx    <= r_shreg[0];
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= 8'd0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_PARITY;
                            r_tx    <= r_p;
                        end else begin
                            r_idx   <= r_idx + c_IDX_ONE;
                            r_shreg <= w_shift_next;
                            r_tx    <= w_shift_next[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= c_STOP;
                        r_cnt   <= 8'd0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 8'd0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 8'd0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_odd_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_odd_parity_serial_tx
// Brief    : Self-checking bench for odd_parity_serial_tx (DATA_W=4,
//            CLKS_PER_BIT=4). Inputs are driven and outputs sampled on the
//            falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odd_parity_serial_tx;

    localparam int DATA_W       = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int NBITS        = DATA_W + 3;
    localparam int FRAME        = NBITS * CLKS_PER_BIT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              tx;
    logic              p;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              exp_p;
    } vec_t;

    vec_t vecs[7];

    odd_parity_serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .p       (p),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference parity: count ones and make the total (with p) odd.
    function automatic logic model_parity(input logic [DATA_W-1:0] w);
        int ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(w[i]);
        return (ones % 2 == 0);
    endfunction

    // Reference line level for cycle k (0-based) of a frame carrying w.
    function automatic logic model_tx(input logic [DATA_W-1:0] w, input int k);
        logic bits[NBITS];
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) bits[1+i] = w[i];
        bits[DATA_W+1] = model_parity(w);
        bits[DATA_W+2] = 1'b1;
        return bits[k / CLKS_PER_BIT];
    endfunction

    // Present a word once in_ready is seen; returns at the falling edge
    // after the accepting rising edge.
    task automatic accept(input logic [DATA_W-1:0] w);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Check a whole frame cycle by cycle, then the idle cycle after it.
    task automatic check_frame(input logic [DATA_W-1:0] w, input bit scramble, input bit keep_valid);
        logic [DATA_W-1:0] rx = '0;
        logic              rxp = 1'b0;
        chk("parity_reg", 32'(p), 32'(model_parity(w)));
        for (int k = 0; k < FRAME; k++) begin
            chk($sformatf("tx_w%0h_k%0d", w, k), 32'(tx), 32'(model_tx(w, k)));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("ready_in_frame", 32'(in_ready), 32'd0);
            for (int b = 0; b < DATA_W; b++)
                if (k == (1 + b) * CLKS_PER_BIT + CLKS_PER_BIT / 2) rx[b] = tx;
            if (k == (DATA_W + 1) * CLKS_PER_BIT + CLKS_PER_BIT / 2) rxp = tx;
            if (scramble) in_data = DATA_W'($urandom);
            if (keep_valid) in_valid = 1'b1;
            else if (k == FRAME - 1) in_valid = 1'b0;
            else if (scramble) in_valid = 1'($urandom);
            @(negedge clk);
        end
        chk("rx_data", 32'(rx), 32'(w));
        chk("rx_odd_ones", 32'(^{rx, rxp}), 32'd1);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'b0000, 1'b1};
        vecs[1] = '{4'b0001, 1'b0};
        vecs[2] = '{4'b1010, 1'b1};
        vecs[3] = '{4'b0111, 1'b0};
        vecs[4] = '{4'b0110, 1'b1};
        vecs[5] = '{4'b1111, 1'b1};
        vecs[6] = '{4'b1000, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed table with hand-computed parity
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].data);
            chk($sformatf("vec%0d_p", i), 32'(p), 32'(vecs[i].exp_p));
            check_frame(vecs[i].data, 1'b0, 1'b0);
        end

        // Inputs changing every cycle during a frame of 0110
        accept(4'b0110);
        check_frame(4'b0110, 1'b1, 1'b0);

        // Sweep all values
        for (int v = 0; v < 16; v++) begin
            accept(DATA_W'(v));
            check_frame(DATA_W'(v), 1'b0, 1'b0);
        end

        // Back-to-back with in_valid held: one idle cycle between frames
        accept(4'b1010);
        chk("b2b_p0", 32'(p), 32'd1);
        check_frame(4'b1010, 1'b0, 1'b1);
        in_data  = 4'b0111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_p1", 32'(p), 32'd0);
        check_frame(4'b0111, 1'b0, 1'b0);

        // Reset during DATA of 1111 aborts the frame
        accept(4'b1111);
        for (int k = 0; k < 6; k++) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        chk("abort_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("abort_no_resume", 32'(tx), 32'd1);
            @(negedge clk);
        end
        accept(4'b0101);
        check_frame(4'b0101, 1'b0, 1'b0);

        // Reset on the same edge as a would-be acceptance
        in_valid = 1'b1;
        in_data  = 4'b0011;
        rst      = 1'b1;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_tx", 32'(tx), 32'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        // Randomized words with scrambled inputs during frames
        for (int r = 0; r < 20; r++) begin
            logic [DATA_W-1:0] w;
            w = DATA_W'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
            accept(w);
            check_frame(w, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/odd_parity_serial_tx.md
ODD_PARITY_SERIAL_TX -- requirements
Module: odd_parity_serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, payload width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data  input  DATA_W  parallel word to send.
REQ-006 The block SHALL have port in_valid  input  1  in_data is presented for transfer.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port p  output  1  odd-parity bit of the word currently held.
REQ-010 The block SHALL have port busy  output  1  a frame is in progress.

Function
REQ-011 The block SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, and SHALL latch in_data into an internal shift register.
REQ-012 in_ready SHALL be 1 only in state IDLE with rst=0; it SHALL be 0 in every other state.
REQ-013 At acceptance, p SHALL be registered as ~^in_data, so the ones count of {p, data} is odd; p SHALL hold until the next acceptance.
REQ-014 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP, in that order; STOP SHALL return to IDLE.
REQ-015 Transitions: IDLE->START on acceptance; START->DATA, PARITY->STOP and STOP->IDLE each after CLKS_PER_BIT cycles; DATA->PARITY after DATA_W bit periods.
REQ-016 tx SHALL be 1 in IDLE, 0 in START, the current data bit (LSB first) in DATA, p in PARITY, and 1 in STOP.
REQ-017 tx SHALL be registered; the start bit SHALL appear on the first cycle after acceptance.
REQ-018 Each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-019 Frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-020 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and SHALL clear on every state change.
REQ-021 A bit index SHALL count 0..DATA_W-1 in DATA and SHALL not wrap past DATA_W-1.
REQ-022 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-023 in_data and in_valid SHALL be ignored while busy; changes during a frame SHALL not affect tx.
REQ-024 With in_valid held high, the next word SHALL be accepted on the first IDLE cycle after STOP, giving a minimum gap of exactly one idle-high cycle between frames.
REQ-025 With CLKS_PER_BIT=1, every state except IDLE SHALL last one cycle per bit, with no skipped or duplicated bits.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL enter IDLE with tx=1, busy=0, p=0 and counters=0; in_ready SHALL be 0 while rst=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next cycle; no partial frame SHALL resume after release.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 rst SHALL take priority over an acceptance on the same edge.

Verification (DATA_W=4, CLKS_PER_BIT=4)
REQ-030 Send in_data=4'b0000 -> p=1; tx sequence per bit is 0,0,0,0,0,1,1, each bit 4 cycles, 28 cycles in total.
REQ-031 Send in_data=4'b0001 -> p=0; tx sequence is 0,1,0,0,0,0,1 (LSB first).
REQ-032 Sweep all 16 values of in_data, sampling tx mid-bit in a bench receiver -> recovered data equals the sent word and the ones count of {data, p} is odd for every value.
REQ-033 Hold in_valid=1 with 4'b1010 then 4'b0111 -> p=1 then p=0; exactly one tx=1 idle cycle between the STOP of the first frame and the START of the second; in_ready pulses for one cycle per word.
REQ-034 Assert rst for 1 cycle during DATA of 4'b1111 -> tx=1, busy=0 the next cycle; in_ready=1 the cycle after release; a new word then sends a complete, correct frame.
REQ-035 Change in_data every cycle during a frame of 4'b0110 -> tx still carries 0,0,1,1,0,1,1 (start, data 0,1,1,0, p=1, stop).
